// File: rtl/seg7_scan_rx_if.sv
// Bundles the scanned 7-segment lines and the frame read-back handshake.
// The display side drives the master modport and the decoder sits on the slave modport.
interface seg7_scan_rx_if #(
  parameter int NDIG = 4
);
  logic [6:0]        seg;
  logic [NDIG-1:0]   dig_sel;
  logic              out_ready;
  logic              out_valid;
  logic [4*NDIG-1:0] bcd;
  logic              out_bad;
  logic              seq_err;
  logic              overrun;

  modport master (
    output seg, dig_sel, out_ready,
    input  out_valid, bcd, out_bad, seq_err, overrun
  );

  modport slave (
    input  seg, dig_sel, out_ready,
    output out_valid, bcd, out_bad, seq_err, overrun
  );
endinterface

// File: rtl/seg7_scan_rx.sv
// Scanned 7-segment bus decoder: qualifies stable {seg, dig_sel} dwells, decodes
// them back to BCD and emits whole NDIG-digit frames on a valid/ready interface.
module seg7_scan_rx #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input logic           clk,
  input logic           rst_n,
  seg7_scan_rx_if.slave bus
);
  localparam int IW = $clog2(NDIG + 1);

  typedef enum logic [1:0] {HUNT, SCAN, COMPLETE} state_t;

  state_t            r_state, w_next;
  logic [6:0]        r_seg;
  logic [NDIG-1:0]   r_sel;
  logic [3:0]        r_cnt;
  logic              r_cap;
  logic [IW-1:0]     r_idx;
  logic [4*NDIG-1:0] r_slots, r_bcd;
  logic              r_bad, r_valid, r_out_bad, r_seq_err, r_overrun;

  logic       w_same, w_onehot, w_is_d0, w_expect, w_illegal;
  logic [3:0] w_code;
  logic       w_start, w_store, w_abort, w_load, w_drop;

  function automatic logic [3:0] f_decode(input logic [6:0] p);
    case (p)
      7'h3F:   return 4'h0;
      7'h06:   return 4'h1;
      7'h5B:   return 4'h2;
      7'h4F:   return 4'h3;
      7'h66:   return 4'h4;
      7'h6D:   return 4'h5;
      7'h7D:   return 4'h6;
      7'h07:   return 4'h7;
      7'h7F:   return 4'h8;
      7'h6F:   return 4'h9;
      7'h00:   return 4'hF;
      default: return 4'hE;
    endcase
  endfunction

  assign w_same    = ({bus.seg, bus.dig_sel} == {r_seg, r_sel});
  assign w_code    = f_decode(r_seg);
  assign w_illegal = (w_code == 4'hE);
  assign w_onehot  = ((r_sel & (r_sel - NDIG'(1))) == '0);
  assign w_is_d0   = (r_sel == NDIG'(1));
  assign w_expect  = (r_sel == (NDIG'(1) << r_idx));

  // r_cap marks the edge where the dwell counter reaches STABLE; the FSM acts
  // on it one edge later while r_seg/r_sel still hold the captured pair.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg <= '0;
      r_sel <= '0;
      r_cnt <= '0;
      r_cap <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_seg <= bus.seg;
      r_sel <= bus.dig_sel;
      r_cap <= w_same && (r_cnt == 4'(STABLE - 1)) && (bus.dig_sel != '0);
      if (!w_same)                     r_cnt <= 4'd1;
      else if (r_cnt != 4'(STABLE))    r_cnt <= r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= HUNT;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    w_next = r_state;
    case (r_state)
      HUNT:     if (r_cap && w_is_d0) w_next = SCAN;
      SCAN:     if (r_cap) begin
                  if (w_onehot && w_expect) begin
                    if (r_idx == IW'(NDIG - 1)) w_next = COMPLETE;
                  end else if (!w_is_d0) begin
                    w_next = HUNT;
                  end
                end
      COMPLETE: w_next = (r_cap && w_is_d0) ? SCAN : HUNT;
      default:  w_next = HUNT;
    endcase
  end

  always_comb begin
    w_start = 1'b0;
    w_store = 1'b0;
    w_abort = 1'b0;
    w_load  = 1'b0;
    w_drop  = 1'b0;
    case (r_state)
      HUNT:     w_start = r_cap && w_is_d0;
      SCAN:     if (r_cap) begin
                  if (w_onehot && w_expect) begin
                    w_store = 1'b1;
                  end else begin
                    w_abort = 1'b1;
                    w_start = w_is_d0;
                  end
                end
      COMPLETE: begin
                  w_load  = !r_valid || bus.out_ready;
                  w_drop  = !w_load;
                  w_start = r_cap && w_is_d0;
                end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the slot store is a handful of flops, reset so a stale frame can never leak out.
      r_slots   <= '0;
      r_idx     <= '0;
      r_bad     <= 1'b0;
      r_valid   <= 1'b0;
      r_bcd     <= '0;
      r_out_bad <= 1'b0;
      r_seq_err <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_seq_err <= w_abort;
      r_overrun <= w_drop;
      if (w_start) begin
        r_slots[3:0] <= w_code;
        r_bad        <= w_illegal;
        r_idx        <= IW'(1);
      end else if (w_store) begin
        for (int i = 0; i < NDIG; i++)
          if (r_idx == IW'(i)) r_slots[4*i +: 4] <= w_code;
        r_bad <= r_bad | w_illegal;
        r_idx <= r_idx + IW'(1);
      end
      if (w_load) begin
        r_valid   <= 1'b1;
        r_bcd     <= r_slots;
        r_out_bad <= r_bad;
      end else if (r_valid && bus.out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.bcd       = r_bcd;
  assign bus.out_bad   = r_out_bad;
  assign bus.seq_err   = r_seq_err;
  assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_seg7_scan_rx.sv
// Directed bench for seg7_scan_rx (NDIG=4, STABLE=3): inputs change on the falling
// edge, outputs are compared on the falling edge, pulse counters sample on the rising edge.
module tb_seg7_scan_rx;
  localparam int NDIG   = 4;
  localparam int STABLE = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0, n_fail = 0, n_checks = 0;
  int   n_seq = 0, n_ovr = 0, n_acc = 0, acc_snap = 0;

  seg7_scan_rx_if #(.NDIG(NDIG)) bus ();

  seg7_scan_rx #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.seq_err === 1'b1)                          n_seq++;
    if (bus.overrun === 1'b1)                          n_ovr++;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) n_acc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] sel, input logic [6:0] sg, input int n);
    bus.seg     = sg;
    bus.dig_sel = sel;
    repeat (n) @(negedge clk);
  endtask

  task automatic digit(input int i, input logic [6:0] sg);
    hold(4'(1 << i), sg, 4);
    hold(4'b0000, 7'h00, 1);
  endtask

  task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    digit(0, s0);
    digit(1, s1);
    digit(2, s2);
    digit(3, s3);
  endtask

  initial begin
    bus.seg       = 7'h00;
    bus.dig_sel   = 4'b0000;
    bus.out_ready = 1'b0;

    // Reset held for three edges while digit 0 is being scanned.
    hold(4'b0001, 7'h3F, 3);
    check("rst_valid",   32'(bus.out_valid), 32'h0);
    check("rst_bcd",     32'(bus.bcd),       32'h0);
    check("rst_bad",     32'(bus.out_bad),   32'h0);
    check("rst_seq_err", 32'(bus.seq_err),   32'h0);
    check("rst_overrun", 32'(bus.overrun),   32'h0);
    rst_n = 1'b1;
    hold(4'b0001, 7'h3F, 1);
    hold(4'b0000, 7'h00, 1);
    digit(1, 7'h06);
    digit(2, 7'h5B);
    digit(3, 7'h4F);
    check("rst_partial_valid", 32'(bus.out_valid), 32'h0);

    // Clean frame 3,4,6,9 with latency check on the last digit.
    digit(0, 7'h4F);
    digit(1, 7'h66);
    digit(2, 7'h7D);
    hold(4'b1000, 7'h6F, 4);
    check("lat_early_valid", 32'(bus.out_valid), 32'h0);
    hold(4'b0000, 7'h00, 1);
    check("lat_valid", 32'(bus.out_valid), 32'h1);
    check("clean_bcd", 32'(bus.bcd),       32'h9643);
    check("clean_bad", 32'(bus.out_bad),   32'h0);
    bus.out_ready = 1'b1;
    hold(4'b0000, 7'h00, 1);
    check("accept_clear", 32'(bus.out_valid), 32'h0);

    // Glitch inside digit 1, illegal 0x49 on digit 1, blank on digit 3.
    digit(0, 7'h3F);
    hold(4'b0010, 7'h7F, 2);
    hold(4'b0010, 7'h49, 4);
    hold(4'b0000, 7'h00, 1);
    digit(2, 7'h5B);
    digit(3, 7'h00);
    check("glitch_valid",  32'(bus.out_valid), 32'h1);
    check("glitch_bcd",    32'(bus.bcd),       32'hF2E0);
    check("glitch_bad",    32'(bus.out_bad),   32'h1);
    check("glitch_no_err", 32'(n_seq),         32'h0);

    // Digit 0 then digit 2: one seq_err, then a full frame recovers.
    digit(0, 7'h3F);
    digit(2, 7'h5B);
    check("seq_err_once", 32'(n_seq), 32'h1);
    frame(7'h06, 7'h5B, 7'h4F, 7'h66);
    check("recover_valid", 32'(bus.out_valid), 32'h1);
    check("recover_bcd",   32'(bus.bcd),       32'h4321);
    check("recover_bad",   32'(bus.out_bad),   32'h0);

    // Two-hot select held three cycles mid-frame aborts it.
    hold(4'b0000, 7'h00, 2);
    acc_snap = n_acc;
    digit(0, 7'h3F);
    digit(1, 7'h06);
    hold(4'b0110, 7'h3F, 3);
    hold(4'b0000, 7'h00, 1);
    digit(2, 7'h5B);
    digit(3, 7'h4F);
    hold(4'b0000, 7'h00, 2);
    check("twohot_seq_err",  32'(n_seq),  32'h2);
    check("twohot_no_frame", 32'(n_acc),  32'(acc_snap));

    // Backpressure: first frame held, second dropped with one overrun.
    bus.out_ready = 1'b0;
    frame(7'h07, 7'h7F, 7'h6F, 7'h3F);
    check("bp_first_valid", 32'(bus.out_valid), 32'h1);
    check("bp_first_bcd",   32'(bus.bcd),       32'h0987);
    frame(7'h06, 7'h06, 7'h06, 7'h06);
    check("bp_held_valid", 32'(bus.out_valid), 32'h1);
    check("bp_held_bcd",   32'(bus.bcd),       32'h0987);

    // Ready raised exactly in the COMPLETE cycle of the third frame.
    digit(0, 7'h6D);
    digit(1, 7'h6D);
    digit(2, 7'h6D);
    hold(4'b1000, 7'h6D, 4);
    check("no_dip_pre", 32'(bus.out_valid), 32'h1);
    bus.out_ready = 1'b1;
    hold(4'b0000, 7'h00, 1);
    check("no_dip_valid", 32'(bus.out_valid), 32'h1);
    check("late_load_bcd", 32'(bus.bcd),      32'h5555);
    hold(4'b0000, 7'h00, 1);
    check("late_accept_clear", 32'(bus.out_valid), 32'h0);
    check("overrun_once",      32'(n_ovr),         32'h1);

    // Reset for one cycle after digit 1 is captured.
    acc_snap = n_acc;
    digit(0, 7'h3F);
    digit(1, 7'h06);
    rst_n = 1'b0;
    hold(4'b0000, 7'h00, 1);
    rst_n = 1'b1;
    check("midrst_bcd",   32'(bus.bcd),       32'h0);
    check("midrst_valid", 32'(bus.out_valid), 32'h0);
    digit(2, 7'h5B);
    digit(3, 7'h4F);
    hold(4'b0000, 7'h00, 3);
    check("midrst_no_frame", 32'(n_acc),         32'(acc_snap));
    check("midrst_idle",     32'(bus.out_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/seg7_scan_rx.md
# seg7_scan_rx

Receive-side decoder for a multiplexed 7-segment display bus. It watches the scanned segment lines and one-hot digit selects that the display driver produces, and filters out glitches with a stability qualifier. It converts each settled segment pattern back to a BCD code and assembles complete frames of NDIG digits. Each frame is delivered on a valid/ready interface, so display contents can be checked or read back in-system.

## Interface
- NDIG, 4, number of scanned digits (2..8); digit 0 is scanned first
- STABLE, 3, consecutive clock edges a {seg, dig_sel} value must hold before it is captured (2..15)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- seg  input  7  segment lines, active-high; seg[0]=a, seg[1]=b, seg[2]=c, seg[3]=d, seg[4]=e, seg[5]=f, seg[6]=g
- dig_sel  input  NDIG  digit select, active-high, one-hot while a digit is driven; all-zero is an inter-digit blanking gap
- out_ready  input  1  consumer accepts the frame
- out_valid  output  1  frame available; held until accepted
- bcd  output  4*NDIG  digit i at bcd[4i+3:4i]
- out_bad  output  1  frame contains at least one illegal pattern; qualified by out_valid
- seq_err  output  1  one-cycle pulse when a frame is aborted
- overrun  output  1  one-cycle pulse when a completed frame is dropped

## Operation
- Input stage:
  - seg and dig_sel are registered once (s_seg, s_sel).
  - cnt (4 bits, saturating at STABLE) resets to 1 whenever {s_seg, s_sel} differs from the previous cycle; otherwise it increments.
- Capture:
  - A capture event fires on the edge where cnt becomes STABLE. This happens exactly once per dwell.
  - s_sel all-zero never produces a capture.
  - s_sel with more than one bit set aborts the frame.
- Segment decode, {g..a} -> code:
  - 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9
  - 0x00 -> 4'hF (blank digit, legal)
  - any other pattern -> 4'hE, and the frame's bad flag is set
- State machine:
  - HUNT: wait for a capture with s_sel == 1 (digit 0). Store code into slot 0, clear the bad flag, set idx=1, go to SCAN. Captures of any other digit are ignored silently.
  - SCAN: the expected capture has s_sel == 1<<idx. On a match, store into slot idx and increment idx. When idx reaches NDIG, go to COMPLETE.
  - SCAN abort: a capture of the wrong digit, or a non-one-hot s_sel, pulses seq_err and returns to HUNT. If the wrong digit is digit 0, it restarts the frame directly in SCAN with idx=1 and still pulses seq_err.
  - COMPLETE: lasts one cycle. If out_valid=0, or out_valid=1 with out_ready=1 this cycle, the slots load into bcd/out_bad and out_valid is set. Otherwise the frame is dropped, overrun pulses, and bcd is left unchanged. Then return to HUNT.
- Output handshake:
  - out_valid clears on the edge where out_valid & out_ready, unless a new frame loads on that same edge.
  - bcd and out_bad are stable while out_valid=1.
- Reset:
  - Returns to HUNT with cnt=0 and slots cleared.
  - out_valid=0, bcd=0, out_bad=0, seq_err=0, overrun=0.
  - A partial frame is discarded, and a pending unaccepted frame is lost.

## Timing
- A pair is first registered at edge t0, and the capture fires at edge t0+STABLE-1. For STABLE=3, a value presented before edge t0 must stay present through edge t0+2.
- Dwells shorter than STABLE edges are glitches: no capture and no error.
- Final-digit capture at edge tc -> COMPLETE during cycle tc+1 -> out_valid high after edge tc+2.
- Minimum gap between frames equals the scan period; there is no extra dead time after COMPLETE.
- seq_err and overrun are registered pulses, each asserted for exactly one cycle.
- The ready-to-valid path is combinational only inside the COMPLETE load decision. No output depends combinationally on any input.

## Test plan
- Reset: hold rst_n=0 for 3 cycles during active scanning -> all outputs 0. Frame reassembly starts only from the next digit-0 capture after release.
- Clean frame: NDIG=4, STABLE=3, dwell 4 cycles each, with 1-cycle all-zero gaps, on patterns 0x4F, 0x66, 0x7D, 0x6F for digits 0..3 -> bcd=16'h9643, out_bad=0, out_valid 2 cycles after the digit-3 capture.
- Glitch and illegal: a 2-cycle dwell of 0x7F inside digit 1's slot, then a digit-1 dwell of 0x49 -> no capture from the glitch. Frame completes with digit 1 = 4'hE and out_bad=1. Blank 0x00 on digit 3 gives 4'hF.
- Sequence error: captures for digit 0, digit 2 -> seq_err pulses once, state returns to HUNT. Next full 0..3 frame is delivered correctly. A two-hot dig_sel held 3 cycles mid-frame also pulses seq_err.
- Backpressure: out_ready=0 across two complete frames -> the first frame is held unchanged, overrun pulses once at the second COMPLETE. Raising out_ready exactly in a COMPLETE cycle -> the new frame loads, with no overrun and no dip in out_valid.
- Reset mid-frame: assert rst_n=0 for 1 cycle after digit 1 is captured -> no frame emitted from the remaining digits 2..3.
